// File: rtl/hdc_train_sched.sv
// Training sequencer for the HDC class-hypervector datapath: paces samples into the
// class-update controller, runs binarization at each epoch end, and repeats for every epoch.
//
// state         | meaning
// S_IDLE        | waiting for start
// S_WAIT_SAMPLE | ready for the next encoded sample
// S_UPDATE      | class update in flight (class_start on first cycle)
// S_BINARIZE    | binarization in flight (bin_start on first cycle)
// S_DONE        | all epochs complete, train_finished held
module hdc_train_sched #(
  parameter int NUM_SAMPLES     = 6238,
  parameter int NUM_EPOCHS      = 1,
  parameter int SEQ_CYCLE_COUNT = 4,
  localparam int SW = $clog2(NUM_SAMPLES > 1 ? NUM_SAMPLES : 2),
  localparam int EW = $clog2(NUM_EPOCHS > 1 ? NUM_EPOCHS : 2),
  localparam int CW = $clog2(SEQ_CYCLE_COUNT + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          en,
  input  logic          start,
  input  logic          abort,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          class_start,
  output logic          bin_start,
  output logic [SW-1:0] sample_idx,
  output logic [EW-1:0] epoch_idx,
  output logic          busy,
  output logic          train_finished
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAMPLE,
    S_UPDATE,
    S_BINARIZE,
    S_DONE
  } state_t;

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(NUM_SAMPLES - 1);
  localparam logic [EW-1:0] EPOCH_LAST  = EW'(NUM_EPOCHS - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(SEQ_CYCLE_COUNT);

  state_t        state_q, state_d;
  logic [SW-1:0] sample_idx_q, sample_idx_d;
  logic [EW-1:0] epoch_idx_q, epoch_idx_d;
  logic [CW-1:0] wait_ctr_q, wait_ctr_d;
  logic          sample_ready_q, class_start_q, bin_start_q, busy_q, train_finished_q;

  always_comb begin
    state_d      = state_q;
    sample_idx_d = sample_idx_q;
    epoch_idx_d  = epoch_idx_q;
    wait_ctr_d   = wait_ctr_q;
    if (abort) begin
      state_d      = S_IDLE;
      sample_idx_d = '0;
      epoch_idx_d  = '0;
      wait_ctr_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start && en) begin
            state_d      = S_WAIT_SAMPLE;
            sample_idx_d = '0;
            epoch_idx_d  = '0;
            wait_ctr_d   = '0;
          end
        end
        S_WAIT_SAMPLE: begin
          if (sample_valid && en) begin
            state_d    = S_UPDATE;
            wait_ctr_d = '0;
          end
        end
        // Update and binarize run to completion regardless of en.
        S_UPDATE: begin
          wait_ctr_d = wait_ctr_q + CW'(1);
          if (wait_ctr_q == WAIT_LAST) begin
            wait_ctr_d = '0;
            if (sample_idx_q == SAMPLE_LAST) begin
              sample_idx_d = '0;
              state_d      = S_BINARIZE;
            end else begin
              sample_idx_d = sample_idx_q + SW'(1);
              state_d      = S_WAIT_SAMPLE;
            end
          end
        end
        S_BINARIZE: begin
          wait_ctr_d = wait_ctr_q + CW'(1);
          if (wait_ctr_q == WAIT_LAST) begin
            wait_ctr_d = '0;
            if (epoch_idx_q == EPOCH_LAST) begin
              state_d = S_DONE;
            end else begin
              epoch_idx_d = epoch_idx_q + EW'(1);
              state_d     = S_WAIT_SAMPLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered copies of the next-state decode, so they track state_q exactly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= S_IDLE;
      sample_idx_q     <= '0;
      epoch_idx_q      <= '0;
      wait_ctr_q       <= '0;
      sample_ready_q   <= 1'b0;
      class_start_q    <= 1'b0;
      bin_start_q      <= 1'b0;
      busy_q           <= 1'b0;
      train_finished_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      sample_idx_q     <= sample_idx_d;
      epoch_idx_q      <= epoch_idx_d;
      wait_ctr_q       <= wait_ctr_d;
      sample_ready_q   <= (state_d == S_WAIT_SAMPLE);
      class_start_q    <= (state_d == S_UPDATE) && (wait_ctr_d == '0);
      bin_start_q      <= (state_d == S_BINARIZE) && (wait_ctr_d == '0);
      busy_q           <= (state_d != S_IDLE) && (state_d != S_DONE);
      train_finished_q <= (state_d == S_DONE);
    end
  end

  assign sample_ready   = sample_ready_q;
  assign class_start    = class_start_q;
  assign bin_start      = bin_start_q;
  assign sample_idx     = sample_idx_q;
  assign epoch_idx      = epoch_idx_q;
  assign busy           = busy_q;
  assign train_finished = train_finished_q;

endmodule
